// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// One result bit per cycle; the unit also provides a registered MFHI/MFLO write port.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  mf_sel,
  input  logic [4:0]  mf_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        WE,
  output logic [4:0]  W_ADDR,
  output logic [31:0] Din
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 5;
  localparam int unsigned LAST = W - 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    wrk_q, wrk_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            we_q, we_d;
  logic [4:0]      w_addr_q, w_addr_d;
  logic [W-1:0]    din_q, din_d;

  logic            is_mul;
  logic [W:0]      sum;
  logic [W:0]      shifted;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    quo, rem;

  assign is_mul = ~op_q[1];

  // Next-state, datapath step and move-port logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    b_d      = b_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    we_d     = 1'b0;
    w_addr_d = 5'd0;
    din_d    = 32'd0;
    sum      = '0;
    shifted  = '0;
    prod     = '0;
    quo      = '0;
    rem      = '0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d    = op;
          sa_d    = op[0] & A[W-1];
          sb_d    = op[0] & B[W-1];
          wrk_d   = (op[0] & A[W-1]) ? (~A + 32'd1) : A;
          b_d     = (op[0] & B[W-1]) ? (~B + 32'd1) : B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (is_mul) begin
          sum = wrk_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};
          {acc_d, wrk_d} = {sum, wrk_q[W-1:1]};
        end else begin
          // Restoring divide: remainder always stays below the divisor, so 33 bits suffice.
          shifted = {acc_q, wrk_q[W-1]};
          if (shifted >= {1'b0, b_q}) begin
            acc_d = W'(shifted - {1'b0, b_q});
            wrk_d = {wrk_q[W-2:0], 1'b1};
          end else begin
            acc_d = shifted[W-1:0];
            wrk_d = {wrk_q[W-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CW'(LAST)) state_d = FIX;
      end
      FIX: begin
        if (is_mul) begin
          prod = (sa_q ^ sb_q) ? (~{acc_q, wrk_q} + 64'd1) : {acc_q, wrk_q};
          hi_d = prod[2*W-1:W];
          lo_d = prod[W-1:0];
        end else begin
          // Divide by zero: quotient all ones, remainder sign-restored to the raw dividend.
          quo  = (b_q == '0) ? '1 : ((sa_q ^ sb_q) ? (~wrk_q + 32'd1) : wrk_q);
          rem  = sa_q ? (~acc_q + 32'd1) : acc_q;
          hi_d = rem;
          lo_d = quo;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == IDLE || state_q == DONE) &&
        (mf_sel == 2'b01 || mf_sel == 2'b10) && (mf_addr != 5'd0)) begin
      we_d     = 1'b1;
      w_addr_d = mf_addr;
      din_d    = (mf_sel == 2'b01) ? lo_q : hi_q;
    end

    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      wrk_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      w_addr_q <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      w_addr_q <= w_addr_d;
      din_q    <= din_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign WE     = we_q;
  assign W_ADDR = w_addr_q;
  assign Din    = din_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: arithmetic, latency, move port, reset abort.
module tb_muldiv_unit;

  logic        clk, rst_n, start;
  logic [1:0]  op, mf_sel;
  logic [31:0] A, B;
  logic [4:0]  mf_addr;
  logic        busy, done, WE;
  logic [31:0] HI, LO, Din;
  logic [4:0]  W_ADDR;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .mf_sel(mf_sel), .mf_addr(mf_addr), .busy(busy), .done(done),
    .HI(HI), .LO(LO), .WE(WE), .W_ADDR(W_ADDR), .Din(Din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present an operation for one edge; returns 1 time unit after the start edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Wait for done; exp_edges counts edges from the call point.
  task automatic wait_done(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_edges));
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    start_op(o, a, b);
    wait_done(tag, 33);
    check({tag, "_hi"}, HI, ehi);
    check({tag, "_lo"}, LO, elo);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0; mf_sel = 2'b00; mf_addr = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(WE), 32'd0);
    check("rst_waddr", 32'(W_ADDR), 32'd0);
    check("rst_din", Din, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-scale unsigned product, then MFHI issued in the DONE cycle.
    start_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 33);
    check("multu_max_hi", HI, 32'hFFFF_FFFE);
    check("multu_max_lo", LO, 32'h0000_0001);
    mf_sel = 2'b10; mf_addr = 5'd5;
    @(posedge clk); #1;
    mf_sel = 2'b00; mf_addr = 5'd0;
    check("mfhi_we", 32'(WE), 32'd1);
    check("mfhi_waddr", 32'(W_ADDR), 32'd5);
    check("mfhi_din", Din, 32'hFFFF_FFFE);
    check("mfhi_done_clear", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("mfhi_we_pulse", 32'(WE), 32'd0);

    // MFLO to r0 is suppressed.
    mf_sel = 2'b01; mf_addr = 5'd0;
    @(posedge clk); #1;
    mf_sel = 2'b00;
    check("mflo_r0_we", 32'(WE), 32'd0);

    run_check("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_check("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_check("divu_zero", DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_check("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_check("div_zero_neg", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_check("divu_big", DIVU, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF);

    // Second start and a move during RUN are both ignored; HI/LO hold.
    start_op(MULTU, 32'd3, 32'd5);
    @(posedge clk); #1;
    op = DIVU; A = 32'd1000; B = 32'd9; start = 1'b1;
    mf_sel = 2'b01; mf_addr = 5'd3;
    @(posedge clk); #1;
    start = 1'b0; mf_sel = 2'b00;
    check("busy_move_we", 32'(WE), 32'd0);
    check("busy_lo_hold", LO, 32'h0FFF_FFFF);
    wait_done("restart_ignored", 31);
    check("restart_ignored_hi", HI, 32'd0);
    check("restart_ignored_lo", LO, 32'd15);
    @(posedge clk); #1;

    // Move and start together: move sees pre-operation LO.
    mf_sel = 2'b01; mf_addr = 5'd7;
    start_op(DIVU, 32'd100, 32'd7);
    mf_sel = 2'b00; mf_addr = 5'd0;
    check("move_start_we", 32'(WE), 32'd1);
    check("move_start_waddr", 32'(W_ADDR), 32'd7);
    check("move_start_din", Din, 32'd15);
    wait_done("divu_100_7", 33);
    check("divu_100_7_hi", HI, 32'd2);
    check("divu_100_7_lo", LO, 32'd14);
    @(posedge clk); #1;

    // Reset in RUN cycle 10 aborts immediately.
    start_op(MULTU, 32'd1234, 32'd5678);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_check("post_reset_multu", MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock shared with the register file.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request new operation; sampled only when busy=0.
REQ-006 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 A  input  32  rs operand (register-file read port 1); multiplicand or dividend.
REQ-008 B  input  32  rt operand (register-file read port 2); multiplier or divisor.
REQ-009 mf_sel  input  2  01 MFLO, 10 MFHI, 00/11 no move.
REQ-010 mf_addr  input  5  destination register for a move.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse when HI/LO have just been updated.
REQ-013 HI  output  32  high product or remainder.
REQ-014 LO  output  32  low product or quotient.
REQ-015 WE, W_ADDR, Din  output  1/5/32  registered write port driving the register file.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, FIX and DONE; busy=1 exactly in RUN and FIX.
REQ-017 IDLE or DONE, start=1 -> latch |A|, |B| (raw values for unsigned ops), operand signs and op; load counter=0; enter RUN.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 RUN SHALL process one bit per cycle (shift-add multiply, restoring divide) for exactly 32 cycles, then enter FIX.
REQ-020 FIX, one cycle: sign-correct results, then load HI/LO and enter DONE.
REQ-021 MULT sign rule: negate the 64-bit product iff the operand signs differ.
REQ-022 DIV sign rule: negate quotient iff signs differ; remainder takes the dividend's sign.
REQ-023 DONE SHALL assert done for one cycle and return to IDLE unless start=1.
REQ-024 Latency: start sampled at edge N -> HI/LO and done valid after edge N+33; busy high after edges N through N+32.
REQ-025 Divide by zero (DIV/DIVU, B=0): HI=A, LO=0xFFFFFFFF; same latency.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0 without any error flag.
REQ-027 Move: with busy=0 and mf_sel=01/10 at edge M, after edge M WE=1, W_ADDR=mf_addr and Din=LO/HI for one cycle.
REQ-028 A move requested while busy=1 SHALL be dropped (WE stays 0); the issuing control stalls on busy.
REQ-029 A move with mf_addr=0 SHALL leave WE=0.
REQ-030 A move sampled in the DONE cycle SHALL return the new HI/LO.
REQ-031 A move and start in the same cycle: the move returns pre-operation HI/LO and start is accepted.
REQ-032 HI/LO SHALL change only on FIX->DONE and on reset.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, WE=0, W_ADDR=0, Din=0, HI=0, LO=0 and clear the internal operand and counter registers.
REQ-034 Reset mid-operation SHALL abort it with no HI/LO update; the first start after release SHALL run normally.

Verification
REQ-035 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done exactly 33 edges after the start edge.
REQ-036 MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-037 DIVU A=7, B=0 -> HI=7, LO=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 After the REQ-035 operation, MFHI mf_addr=5 -> next cycle WE=1, W_ADDR=5, Din=0xFFFFFFFE; MFLO during busy -> WE=0; MFLO mf_addr=0 -> WE=0.
REQ-039 start, then start again during RUN -> second start ignored and results match the first operands only.
REQ-040 rst_n low in RUN cycle 10 -> busy=0, HI=LO=0 at once; next MULTU 3*4 -> LO=12, HI=0.
